// File: rtl/alu_seq.sv
// Sequential 8-bit ALU feeding the D0 register: single-cycle logic/arith ops, iterative
// shift-add multiply and bit-serial shift-left, with a one-cycle write-back pulse and flags.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       wb_we,
    output logic [7:0] wb_data,
    output logic       zero,
    output logic       carry
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StCalc = 3'd1;
    localparam logic [2:0] StMul  = 3'd2;
    localparam logic [2:0] StShl  = 3'd3;
    localparam logic [2:0] StWb   = 3'd4;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpOr   = 3'b011;
    localparam logic [2:0] OpXor  = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpShl  = 3'b110;
    localparam logic [2:0] OpPass = 3'b111;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  wb_data_q, wb_data_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic [8:0]  calc_full;

    // Bit 8 carries the ADD carry-out or the SUB borrow; zero for everything else.
    always_comb begin
        calc_full = 9'h000;
        case (op_q)
            OpAdd:   calc_full = {1'b0, a_q} + {1'b0, b_q};
            OpSub:   calc_full = {1'b0, a_q} - {1'b0, b_q};
            OpAnd:   calc_full = {1'b0, a_q & b_q};
            OpOr:    calc_full = {1'b0, a_q | b_q};
            OpXor:   calc_full = {1'b0, a_q ^ b_q};
            OpShl:   calc_full = {1'b0, a_q};
            OpPass:  calc_full = {1'b0, b_q};
            default: calc_full = 9'h000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        wb_data_d = wb_data_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        case (state_q)
            StIdle, StWb: begin
                state_d = StIdle;
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    mcand_d = {8'h00, a};
                    cnt_d   = 4'd0;
                    if (op == OpMul) begin
                        state_d = StMul;
                        cnt_d   = 4'd8;
                    end else if (op == OpShl && b[2:0] != 3'd0) begin
                        state_d = StShl;
                        cnt_d   = {1'b0, b[2:0]};
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                state_d   = StWb;
                wb_data_d = calc_full[7:0];
                zero_d    = (calc_full[7:0] == 8'h00);
                carry_d   = calc_full[8];
            end
            StMul: begin
                // Multiplier bits are consumed LSB first from b_q.
                acc_d   = acc_q + (b_q[0] ? mcand_q : 16'h0000);
                mcand_d = {mcand_q[14:0], 1'b0};
                b_d     = {1'b0, b_q[7:1]};
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = StWb;
                    wb_data_d = acc_d[7:0];
                    zero_d    = (acc_d[7:0] == 8'h00);
                    carry_d   = |acc_d[15:8];
                end
            end
            StShl: begin
                a_d   = {a_q[6:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = StWb;
                    wb_data_d = {a_q[6:0], 1'b0};
                    zero_d    = (a_q[6:0] == 7'h00);
                    carry_d   = a_q[7];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 3'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            cnt_q     <= 4'd0;
            acc_q     <= 16'h0000;
            mcand_q   <= 16'h0000;
            wb_data_q <= 8'h00;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            wb_data_q <= wb_data_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign busy    = (state_q == StCalc) || (state_q == StMul) || (state_q == StShl);
    assign wb_we   = (state_q == StWb);
    assign wb_data = wb_data_q;
    assign zero    = zero_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       wb_we;
    logic [7:0] wb_data;
    logic       zero;
    logic       carry;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_data;
    logic       exp_zero;
    logic       exp_carry;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .wb_we   (wb_we),
        .wb_data (wb_data),
        .zero    (zero),
        .carry   (carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: result, carry and write-back cycle computed directly from the op rules.
    task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] r, output logic c, output int lat);
        int ix, iy, t, k;
        ix  = int'(x);
        iy  = int'(y);
        lat = 2;
        c   = 1'b0;
        t   = 0;
        case (o)
            3'b000: begin t = ix + iy; c = (t > 255); end
            3'b001: begin t = (ix - iy + 256) % 256; c = (ix < iy); end
            3'b010: t = ix & iy;
            3'b011: t = ix | iy;
            3'b100: t = ix ^ iy;
            3'b101: begin t = ix * iy; c = (t > 255); lat = 9; end
            3'b110: begin
                k = iy % 8;
                t = ix << k;
                if (k > 0) begin
                    c   = ((ix >> (8 - k)) & 1) == 1;
                    lat = k + 1;
                end
            end
            default: t = iy;
        endcase
        r = 8'(t % 256);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input bit noise);
        logic [7:0] r;
        logic       c;
        int         lat;
        model(o, x, y, r, c, lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick;
        start = 1'b0;
        for (int n = 1; n < lat; n++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_we_early"}, 32'(wb_we), 32'd0);
            if (noise && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                op    = 3'($urandom);
                a     = 8'($urandom);
                b     = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        check({tag, "_we"}, 32'(wb_we), 32'd1);
        check({tag, "_busy_wb"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(wb_data), 32'(r));
        check({tag, "_zero"}, 32'(zero), 32'(r == 8'h00));
        check({tag, "_carry"}, 32'(carry), 32'(c));
        exp_data  = r;
        exp_zero  = (r == 8'h00);
        exp_carry = c;
        tick;
        check({tag, "_we_after"}, 32'(wb_we), 32'd0);
        check({tag, "_hold"}, 32'({wb_data, zero, carry}), 32'({exp_data, exp_zero, exp_carry}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_we"}, 32'(wb_we), 32'd0);
        check({tag, "_data"}, 32'(wb_data), 32'h00);
        check({tag, "_zero"}, 32'(zero), 32'd0);
        check({tag, "_carry"}, 32'(carry), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 8'h00;
        b     = 8'h00;
        tick;
        tick;
        check_reset_outputs("reset");
        rst = 1'b0;

        run_op("add_f0_20", 3'b000, 8'hF0, 8'h20, 1'b0);
        run_op("sub_eq", 3'b001, 8'h05, 8'h05, 1'b0);
        run_op("sub_borrow", 3'b001, 8'h03, 8'h04, 1'b0);
        run_op("mul_13_11", 3'b101, 8'h13, 8'h11, 1'b1);
        run_op("mul_0f_03", 3'b101, 8'h0F, 8'h03, 1'b1);
        run_op("shl_c1_3", 3'b110, 8'hC1, 8'h03, 1'b0);
        run_op("shl_81_1", 3'b110, 8'h81, 8'h01, 1'b0);
        run_op("shl_k0", 3'b110, 8'hA7, 8'hF8, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        // start held high: PASS should write back every other cycle.
        start = 1'b1;
        op    = 3'b111;
        a     = 8'h00;
        b     = 8'h5A;
        tick;
        for (int n = 1; n <= 10; n++) begin
            check("b2b_we", 32'(wb_we), 32'(n % 2 == 0));
            if (n % 2 == 0) check("b2b_data", 32'(wb_data), 32'h5A);
            tick;
        end
        start = 1'b0;
        tick;
        tick;
        check("b2b_idle_we", 32'(wb_we), 32'd0);

        // Reset in MUL cycle 4 must abort without a write-back.
        start = 1'b1;
        op    = 3'b101;
        a     = 8'h13;
        b     = 8'h11;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_reset_outputs("mul_abort");
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            check("abort_no_we", 32'(wb_we), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
            tick;
        end

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'b000;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        tick;
        check("rst_prio_we", 32'(wb_we), 32'd0);

        run_op("add_after_rst", 3'b000, 8'h0F, 8'hF1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
